seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Downstream of the game top level.
- Consumes the four per-digit 7-segment patterns (two selected-number digits, two guessed-number digits) and drives one time-multiplexed 4-digit common-anode display.
- Adds frame-coherent snapshotting, anti-ghosting guard time and a PWM brightness control.
- Adds an optional win-blink sequence triggered by the game's BINGO event.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; must be ≥16.
- GUARD, 2, blanked cycles at the start of each slot (anti-ghosting); must be < REFRESH_DIV/2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (used only with the macro).
- BLINK_HALVES, 6, number of blink half-periods per win sequence (dark/lit alternating, dark first).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_in_0  in  8  digit 0 segment pattern, active-high, bit7 = dp
- seg_in_1  in  8  digit 1 pattern
- seg_in_2  in  8  digit 2 pattern
- seg_in_3  in  8  digit 3 pattern
- digit_blank  in  4  per-digit force-off, bit i blanks digit i
- brightness  in  3  0 = dimmest, 7 = full
- win_event  in  1  single-cycle pulse on BINGO
- seg_n  out  8  segment drive, active-low
- an_n  out  4  anode enables, active-low, at most one low
- slot  out  2  currently scanned digit index
- blink_active  out  1  high while the win-blink sequence runs

Behaviour:
- **Reset** (async, immediate):
  - slot=0, refresh counter=0, an_n=4'b1111, seg_n=8'hFF.
  - Shadow registers=0, brightness shadow=7, blink_active=0, blink counters=0.
- **Refresh counter:** cnt counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and slot increments modulo 4 (3→0).
- **Frame snapshot:**
  - On the cycle cnt wraps with slot==3 (frame boundary), seg_in_0..3, digit_blank and brightness are latched into shadows.
  - The same latch happens on the first cycle after reset release.
  - Mid-frame input changes are invisible until the next frame.
- **Per-slot FSM** (registered, evaluated each cycle):
  - GUARD: cnt<GUARD. an_n=1111, seg_n=FF.
  - ON: GUARD≤cnt<GUARD+on_time. an_n has bit slot low, seg_n=~shadow[slot].
  - OFF: remaining cycles of the slot. an_n=1111, seg_n=FF.
  - on_time = ((REFRESH_DIV-GUARD)*(b+1))>>3, where b is the brightness shadow. Compute with 32-bit intermediate width, floor division.
  - b=7 gives ON through cnt=REFRESH_DIV-1 (OFF is empty).
- **Blanking:** if digit_blank shadow bit[slot]=1, ON behaves as OFF for that slot.
- **Output timing:** outputs are registered, one cycle after the cnt value that defines them. an_n and seg_n change only together.
- **Reset mid-slot:** outputs blank in the same cycle and the scan restarts at slot 0, cnt 0.

Optional Feature:
- Macro: SEG_WIN_BLINK_EN.
- **Defined:**
  - A win_event pulse sets blink_active=1 and clears the half-period counter and the halves counter.
  - During even-numbered halves (0, 2, 4) all digits are forced dark; odd halves scan normally.
  - After BLINK_HALVES halves, blink_active drops to 0 and normal scan resumes. The scan counters are never stalled by blinking.
  - win_event while already blinking restarts the sequence from half 0.
  - win_event in the same cycle as rst is ignored.
- **Undefined:** win_event is ignored, blink_active is tied to 0, and no blink logic is synthesized.

Test Plan (REFRESH_DIV=20, GUARD=2, BLINK_DIV=40, BLINK_HALVES=6):
- Static seg_in_0..3 = 3F, 06, 5B, 4F, brightness=7, no blank → an_n cycles 1110, 1101, 1011, 0111. Each is low for 18 cycles after 2 dark cycles. seg_n equals C0, F9, A4, B0 respectively.
- brightness=1 → each digit is lit exactly (18*2)>>3 = 4 cycles per 20-cycle slot. brightness=0 → 2 cycles.
- Change seg_in_2 from 5B to 7F while slot=0 → digit 2 still shows A4 this frame and shows 80 from the next frame.
- digit_blank=4'b0100 → an_n[2] never low over 3 frames; other digits unaffected.
- Assert rst while slot=2 is in ON → an_n=1111 and seg_n=FF in the same cycle. After release, the scan resumes at slot 0 with a 2-cycle guard.
- With SEG_WIN_BLINK_EN, pulse win_event:
  - blink_active is high for 240 cycles.
  - an_n stays 1111 during cycles 0-39, 80-119 and 160-199.
  - A second pulse at cycle 100 extends blink_active to cycle 340.
  - Without the macro, scan output is unchanged and blink_active stays 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode scanner with frame snapshot, guard time and PWM dimming.
// Optional win-blink sequence is built when SEG_WIN_BLINK_EN is defined.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_DIV    = 25000000,
    parameter int BLINK_HALVES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in_0,
    input  logic [7:0] seg_in_1,
    input  logic [7:0] seg_in_2,
    input  logic [7:0] seg_in_3,
    input  logic [3:0] digit_blank,
    input  logic [2:0] brightness,
    input  logic       win_event,
    output logic [7:0] seg_n,
    output logic [3:0] an_n,
    output logic [1:0] slot,
    output logic       blink_active
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_GUARD, S_ON, S_OFF} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot, r_on_slot;
    logic          r_first;
    logic [7:0]    r_shadow [4];
    logic [3:0]    r_blank;
    logic [2:0]    r_bright;
    logic [7:0]    r_pat;
    logic          w_wrap, w_frame, w_dark;
    logic [31:0]   w_on_time, w_cnt32;

    assign w_wrap    = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_frame   = r_first || (w_wrap && r_slot == 2'd3);
    assign w_on_time = (32'(REFRESH_DIV - GUARD) * (32'(r_bright) + 32'd1)) >> 3;
    assign w_cnt32   = 32'(r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_slot    <= '0;
            r_first   <= 1'b1;
            r_shadow  <= '{default: 8'h00};
            r_blank   <= '0;
            r_bright  <= 3'd7;
            r_state   <= S_GUARD;
            r_on_slot <= '0;
            r_pat     <= '0;
        end else begin
            r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            r_slot  <= w_wrap ? r_slot + 1'b1 : r_slot;
            r_first <= 1'b0;
            // Inputs are sampled only at frame boundaries so a frame never mixes old and new data
            if (w_frame) begin
                r_shadow <= '{seg_in_0, seg_in_1, seg_in_2, seg_in_3};
                r_blank  <= digit_blank;
                r_bright <= brightness;
            end
            r_state   <= w_state_nxt;
            r_on_slot <= r_slot;
            r_pat     <= r_shadow[r_slot];
        end
    end

    always_comb begin
        w_state_nxt = S_OFF;
        if (w_cnt32 < 32'(GUARD))
            w_state_nxt = S_GUARD;
        else if (w_cnt32 < 32'(GUARD) + w_on_time && !r_blank[r_slot] && !w_dark)
            w_state_nxt = S_ON;
    end

    assign an_n  = (r_state == S_ON) ? ~(4'b0001 << r_on_slot) : 4'hF;
    assign seg_n = (r_state == S_ON) ? ~r_pat : 8'hFF;
    assign slot  = r_slot;

`ifdef SEG_WIN_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam int HW = $clog2(BLINK_HALVES + 1);

    logic [BW-1:0] r_bcnt;
    logic [HW-1:0] r_halves;
    logic          r_blink;
    logic          w_bwrap;

    assign w_bwrap = r_bcnt == BW'(BLINK_DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink  <= 1'b0;
            r_bcnt   <= '0;
            r_halves <= '0;
        end else if (win_event) begin
            r_blink  <= 1'b1;
            r_bcnt   <= '0;
            r_halves <= '0;
        end else if (r_blink) begin
            r_bcnt <= w_bwrap ? '0 : r_bcnt + 1'b1;
            if (w_bwrap) begin
                r_halves <= r_halves + 1'b1;
                if (r_halves == HW'(BLINK_HALVES - 1))
                    r_blink <= 1'b0;
            end
        end
    end

    // The pulse itself darkens the next output so the dark half starts on the pulse cycle
    assign w_dark       = win_event || (r_blink && !r_halves[0]);
    assign blink_active = r_blink;
`else
    logic [31:0] w_unused_blink;

    assign w_unused_blink = 32'(BLINK_DIV + BLINK_HALVES) ^ {31'd0, win_event};
    assign w_dark         = 1'b0;
    assign blink_active   = 1'b0;
`endif
endmodule
